// File: rtl/ahb_driver.sv
//=============================================================================
// Module      : ahb_driver
// Description : Command FIFO feeding the AHB master plus a response FIFO for
//               returned reads, with read issue throttled to response space.
//               Optional counters enabled by AHB_DRIVER_STATS_EN.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module ahb_driver #(
  parameter  int DWIDTH    = 32,
  parameter  int AWIDTH    = 32,
  parameter  int CMD_DEPTH = 8,
  parameter  int RSP_DEPTH = 4,
  localparam int IW        = DWIDTH + AWIDTH + 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IW-1:0]                  cmd_data,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           run,
  output logic [IW-1:0]                  amba_instr,
  output logic                           amba_en,
  input  logic                           instr_rd,
  input  logic                           amba_wr_flg,
  input  logic [AWIDTH-1:0]              amba_slv_addr,
  input  logic [DWIDTH-1:0]              amba_slv_data,
  output logic [AWIDTH+DWIDTH-1:0]       rsp_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(CMD_DEPTH):0]     cmd_count,
  output logic [1:0]                     rd_pending,
`ifdef AHB_DRIVER_STATS_EN
  output logic [15:0]                    wr_issued,
  output logic [15:0]                    rd_issued,
  output logic [15:0]                    stall_cycles,
`endif
  output logic                           idle
);

  localparam int c_CMD_AW = $clog2(CMD_DEPTH);
  localparam int c_RSP_AW = $clog2(RSP_DEPTH);
  localparam int c_RW     = AWIDTH + DWIDTH;
  localparam logic [c_CMD_AW:0]   c_CMD_FULL = CMD_DEPTH[c_CMD_AW:0];
  localparam logic [c_RSP_AW:0]   c_RSP_FULL = RSP_DEPTH[c_RSP_AW:0];
  localparam logic [c_RSP_AW+1:0] c_RSP_LIM  = RSP_DEPTH[c_RSP_AW+1:0];

  logic [IW-1:0]       r_cmd_mem [CMD_DEPTH];
  logic [c_CMD_AW-1:0] r_cmd_wp;
  logic [c_CMD_AW-1:0] r_cmd_rp;
  logic [c_CMD_AW:0]   r_cmd_cnt;

  logic [c_RW-1:0]     r_rsp_mem [RSP_DEPTH];
  logic [c_RSP_AW-1:0] r_rsp_wp;
  logic [c_RSP_AW-1:0] r_rsp_rp;
  logic [c_RSP_AW:0]   r_rsp_cnt;

  logic [1:0]          r_rd_pend;

  logic                w_cmd_empty;
  logic                w_cmd_full;
  logic                w_rsp_full;
  logic                w_head_wr;
  logic [c_RSP_AW+1:0] w_rsp_load;
  logic                w_rd_ok;
  logic                w_pop;
  logic                w_push;
  logic                w_rd_inc;
  logic                w_rsp_pop;
  logic                w_rsp_push;

  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_cmd_full  = (r_cmd_cnt == c_CMD_FULL);
  assign w_rsp_full  = (r_rsp_cnt == c_RSP_FULL);

  // Head is masked while empty so stale or uninitialised storage never leaks out
  assign amba_instr = w_cmd_empty ? '0 : r_cmd_mem[r_cmd_rp];
  assign w_head_wr  = amba_instr[IW-1];

  // A read may only go out if its eventual return is guaranteed a response slot
  assign w_rsp_load = (c_RSP_AW+2)'(r_rsp_cnt) + (c_RSP_AW+2)'(r_rd_pend);
  assign w_rd_ok    = w_head_wr || (w_rsp_load < c_RSP_LIM);

  assign amba_en    = run && !w_cmd_empty && w_rd_ok;
  assign w_pop      = amba_en && instr_rd;
  assign w_push     = cmd_valid && (!w_cmd_full || w_pop);
  assign w_rd_inc   = w_pop && !w_head_wr;
  assign cmd_ready  = !w_cmd_full;
  assign cmd_count  = r_cmd_cnt;

  assign rsp_valid  = (r_rsp_cnt != '0);
  assign rsp_data   = rsp_valid ? r_rsp_mem[r_rsp_rp] : '0;
  assign w_rsp_pop  = rsp_ready && rsp_valid;
  assign w_rsp_push = amba_wr_flg && (!w_rsp_full || w_rsp_pop);

  assign rd_pending = r_rd_pend;
  assign idle       = w_cmd_empty && (r_rd_pend == 2'd0) && !rsp_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_cmd_mem[r_cmd_wp] <= cmd_data;
    end
    if (w_rsp_push) begin
      r_rsp_mem[r_rsp_wp] <= {amba_slv_addr, amba_slv_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_push) begin
        r_cmd_wp <= r_cmd_wp + 1'b1;
      end
      if (w_pop) begin
        r_cmd_rp <= r_cmd_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + 1'b1;
        2'b01:   r_cmd_cnt <= r_cmd_cnt - 1'b1;
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_wp  <= '0;
      r_rsp_rp  <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_rsp_push) begin
        r_rsp_wp <= r_rsp_wp + 1'b1;
      end
      if (w_rsp_pop) begin
        r_rsp_rp <= r_rsp_rp + 1'b1;
      end
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_cnt <= r_rsp_cnt + 1'b1;
        2'b01:   r_rsp_cnt <= r_rsp_cnt - 1'b1;
        default: r_rsp_cnt <= r_rsp_cnt;
      endcase
    end
  end

  // Outstanding reads: saturating, and a stray return never underflows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend <= 2'd0;
    end else if (w_rd_inc && !amba_wr_flg && (r_rd_pend != 2'd3)) begin
      r_rd_pend <= r_rd_pend + 2'd1;
    end else if (amba_wr_flg && !w_rd_inc && (r_rd_pend != 2'd0)) begin
      r_rd_pend <= r_rd_pend - 2'd1;
    end
  end

`ifdef AHB_DRIVER_STATS_EN
  logic [15:0] r_wr_issued;
  logic [15:0] r_rd_issued;
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_issued    <= '0;
      r_rd_issued    <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_pop && w_head_wr) begin
        r_wr_issued <= r_wr_issued + 16'd1;
      end
      if (w_rd_inc) begin
        r_rd_issued <= r_rd_issued + 16'd1;
      end
      if (run && !w_cmd_empty && (!w_rd_ok || !instr_rd)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign wr_issued    = r_wr_issued;
  assign rd_issued    = r_rd_issued;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_driver.sv
// Self-checking bench for ahb_driver: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
`default_nettype none

module tb_ahb_driver;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CD = 8;
  localparam int RD = 4;
  localparam int IW = DW + AW + 6;
  localparam int RW = AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] cmd_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          run;
  logic [IW-1:0] amba_instr;
  logic          amba_en;
  logic          instr_rd;
  logic          amba_wr_flg;
  logic [AW-1:0] amba_slv_addr;
  logic [DW-1:0] amba_slv_data;
  logic [RW-1:0] rsp_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    cmd_count;
  logic [1:0]    rd_pending;
  logic          idle;

  always #5 clk = ~clk;

  ahb_driver #(.DWIDTH(DW), .AWIDTH(AW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .run(run), .amba_instr(amba_instr), .amba_en(amba_en),
    .instr_rd(instr_rd), .amba_wr_flg(amba_wr_flg), .amba_slv_addr(amba_slv_addr),
    .amba_slv_data(amba_slv_data), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .cmd_count(cmd_count), .rd_pending(rd_pending), .idle(idle)
  );

  typedef struct {
    bit            v;
    logic [IW-1:0] d;
    bit            run;
    bit            ird;
    bit            wf;
    logic [31:0]   a;
    logic [31:0]   dat;
    bit            rr;
    bit            e_en;
    int            e_cnt;
    int            e_pend;
    bit            e_rv;
    logic [RW-1:0] e_rdata;
    logic [IW-1:0] e_instr;
    bit            e_idle;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [IW-1:0] m_cmd[$];
  logic [RW-1:0] m_rsp[$];
  int            m_pend = 0;
  bit            prev_rd_pop = 0;
  int            dut_rd_issues = 0;

  vec_t tbl[17];
  vec_t cur;
  bit   cur_on = 0;

  function automatic logic [IW-1:0] mk(bit w, logic [31:0] a, logic [31:0] d);
    return {w, 3'd2, 2'b10, a, d};
  endfunction

  function automatic vec_t V(bit v, logic [IW-1:0] d, bit r, bit ird, bit wf,
                             logic [31:0] a, logic [31:0] dat, bit rr, bit e_en,
                             int e_cnt, int e_pend, bit e_rv, logic [RW-1:0] e_rdata,
                             logic [IW-1:0] e_instr, bit e_idle);
    vec_t t;
    t.v = v; t.d = d; t.run = r; t.ird = ird; t.wf = wf; t.a = a; t.dat = dat; t.rr = rr;
    t.e_en = e_en; t.e_cnt = e_cnt; t.e_pend = e_pend; t.e_rv = e_rv;
    t.e_rdata = e_rdata; t.e_instr = e_instr; t.e_idle = e_idle;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_en();
    if (!run || m_cmd.size() == 0) return 1'b0;
    if (m_cmd[0][IW-1]) return 1'b1;
    return (m_rsp.size() + m_pend) < RD;
  endfunction

  task automatic zero_in();
    cmd_valid = 0; cmd_data = '0; run = 0; instr_rd = 0; amba_wr_flg = 0;
    amba_slv_addr = '0; amba_slv_data = '0; rsp_ready = 0; rst = 0;
  endtask

  // One clock: check at negedge against the model, advance model at posedge.
  task automatic step();
    bit en, pop, push, rpop, rwr, inc;
    @(negedge clk);
    en = m_en();
    if (amba_en && instr_rd && !amba_instr[IW-1]) dut_rd_issues++;
    chk("cmd_ready", 128'(cmd_ready), 128'(m_cmd.size() < CD));
    chk("amba_en", 128'(amba_en), 128'(en));
    if (en) chk("amba_instr", 128'(amba_instr), 128'(m_cmd[0]));
    chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp.size() > 0));
    if (m_rsp.size() > 0) chk("rsp_data", 128'(rsp_data), 128'(m_rsp[0]));
    chk("cmd_count", 128'(cmd_count), 128'(m_cmd.size()));
    chk("rd_pending", 128'(rd_pending), 128'(m_pend));
    chk("idle", 128'(idle), 128'(m_cmd.size() == 0 && m_pend == 0 && m_rsp.size() == 0));
    if (cur_on) begin
      chk("tbl_en", 128'(amba_en), 128'(cur.e_en));
      chk("tbl_cnt", 128'(cmd_count), 128'(cur.e_cnt));
      chk("tbl_pend", 128'(rd_pending), 128'(cur.e_pend));
      chk("tbl_rv", 128'(rsp_valid), 128'(cur.e_rv));
      chk("tbl_idle", 128'(idle), 128'(cur.e_idle));
      if (cur.e_en) chk("tbl_instr", 128'(amba_instr), 128'(cur.e_instr));
      if (cur.e_rv) chk("tbl_rdata", 128'(rsp_data), 128'(cur.e_rdata));
    end
    pop  = en && instr_rd;
    push = cmd_valid && (m_cmd.size() < CD || pop);
    rpop = rsp_ready && m_rsp.size() > 0;
    rwr  = amba_wr_flg && (m_rsp.size() < RD || rpop);
    inc  = pop && !m_cmd[0][IW-1];
    @(posedge clk);
    if (rst) begin
      m_cmd.delete(); m_rsp.delete(); m_pend = 0; prev_rd_pop = 0;
    end else begin
      if (pop) void'(m_cmd.pop_front());
      if (push) m_cmd.push_back(cmd_data);
      if (rpop) void'(m_rsp.pop_front());
      if (rwr) m_rsp.push_back({amba_slv_addr, amba_slv_data});
      if (inc && !amba_wr_flg) m_pend = (m_pend == 3) ? 3 : m_pend + 1;
      else if (amba_wr_flg && !inc && m_pend > 0) m_pend--;
      prev_rd_pop = inc;
    end
    #1;
  endtask

  task automatic do_reset();
    zero_in(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    int n0;
    logic [IW-1:0] w0, w1;
    zero_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset with three queued words
    run = 0; cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cmd_data = mk(1, 32'h100 + 32'(i), 32'(i)); step();
    end
    chk("pre_rst_count", 128'(cmd_count), 128'(3));
    zero_in(); rst = 1; step(); rst = 0;
    chk("rst_count", 128'(cmd_count), 128'(0));
    chk("rst_en", 128'(amba_en), 128'(0));
    chk("rst_idle", 128'(idle), 128'(1));
    chk("rst_rspv", 128'(rsp_valid), 128'(0));
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_instr_known", 128'($isunknown(amba_instr)), 128'(0));

    // vector table: four writes issued back to back, then a read/return overlap
    tbl[0]  = V(1, mk(1,32'h10,32'hA0), 0,0,0, 0,0,0, 0,0,0,0, '0, '0, 1);
    tbl[1]  = V(1, mk(1,32'h14,32'hA1), 0,0,0, 0,0,0, 0,1,0,0, '0, '0, 0);
    tbl[2]  = V(1, mk(1,32'h18,32'hA2), 0,0,0, 0,0,0, 0,2,0,0, '0, '0, 0);
    tbl[3]  = V(1, mk(1,32'h1C,32'hA3), 0,0,0, 0,0,0, 0,3,0,0, '0, '0, 0);
    tbl[4]  = V(0, '0, 1,1,0, 0,0,0, 1,4,0,0, '0, mk(1,32'h10,32'hA0), 0);
    tbl[5]  = V(0, '0, 1,1,0, 0,0,0, 1,3,0,0, '0, mk(1,32'h14,32'hA1), 0);
    tbl[6]  = V(0, '0, 1,1,0, 0,0,0, 1,2,0,0, '0, mk(1,32'h18,32'hA2), 0);
    tbl[7]  = V(0, '0, 1,1,0, 0,0,0, 1,1,0,0, '0, mk(1,32'h1C,32'hA3), 0);
    tbl[8]  = V(0, '0, 1,1,0, 0,0,0, 0,0,0,0, '0, '0, 1);
    tbl[9]  = V(1, mk(0,32'h20,32'h0), 0,0,0, 0,0,0, 0,0,0,0, '0, '0, 1);
    tbl[10] = V(1, mk(0,32'h24,32'h0), 0,0,0, 0,0,0, 0,1,0,0, '0, '0, 0);
    tbl[11] = V(0, '0, 1,1,0, 0,0,0, 1,2,0,0, '0, mk(0,32'h20,32'h0), 0);
    tbl[12] = V(0, '0, 1,1,1, 32'h20,32'hDEADBEEF,0, 1,1,1,0, '0, mk(0,32'h24,32'h0), 0);
    tbl[13] = V(0, '0, 1,0,0, 0,0,0, 0,0,1,1, {32'h20,32'hDEADBEEF}, '0, 0);
    tbl[14] = V(0, '0, 1,0,1, 32'h24,32'h12345678,1, 0,0,1,1, {32'h20,32'hDEADBEEF}, '0, 0);
    tbl[15] = V(0, '0, 1,0,0, 0,0,1, 0,0,0,1, {32'h24,32'h12345678}, '0, 0);
    tbl[16] = V(0, '0, 0,0,0, 0,0,0, 0,0,0,0, '0, '0, 1);
    for (int i = 0; i < 17; i++) begin
      cur = tbl[i]; cur_on = 1;
      cmd_valid = cur.v; cmd_data = cur.d; run = cur.run; instr_rd = cur.ird;
      amba_wr_flg = cur.wf; amba_slv_addr = cur.a; amba_slv_data = cur.dat;
      rsp_ready = cur.rr;
      step();
    end
    cur_on = 0;
    zero_in();

    // fill: nine pushes into an eight-deep FIFO with issue frozen
    cmd_valid = 1;
    for (int i = 0; i < 9; i++) begin
      cmd_data = mk(1, 32'h200 + 32'(4*i), $urandom);
      step();
      if (i == 7) begin
        chk("full_ready", 128'(cmd_ready), 128'(0));
        chk("full_count8", 128'(cmd_count), 128'(8));
      end
    end
    chk("full_count9", 128'(cmd_count), 128'(8));
    cmd_valid = 0; run = 1; instr_rd = 1;
    repeat (10) step();
    chk("drain_empty", 128'(cmd_count), 128'(0));

    // instr_rd held low mid-stream
    zero_in(); cmd_valid = 1;
    w0 = mk(1, 32'h300, 32'h55); w1 = mk(1, 32'h304, 32'h66);
    cmd_data = w0; step();
    cmd_data = w1; step();
    cmd_data = mk(1, 32'h308, 32'h77); step();
    cmd_valid = 0; run = 1; instr_rd = 1; step();
    instr_rd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_en", 128'(amba_en), 128'(1));
      chk("hold_instr", 128'(amba_instr), 128'(w1));
      chk("hold_count", 128'(cmd_count), 128'(2));
    end
    instr_rd = 1; repeat (3) step();

    // read throttle against a four-entry response FIFO
    do_reset();
    cmd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      cmd_data = mk(0, 32'h400 + 32'(4*i), 32'h0); step();
    end
    cmd_valid = 0; run = 1; instr_rd = 1; rsp_ready = 0;
    n0 = dut_rd_issues;
    for (int i = 0; i < 12; i++) begin
      amba_wr_flg = prev_rd_pop; amba_slv_addr = $urandom; amba_slv_data = $urandom;
      step();
    end
    chk("throttle_issued4", 128'(dut_rd_issues - n0), 128'(4));
    chk("throttle_en_low", 128'(amba_en), 128'(0));
    amba_wr_flg = 0; rsp_ready = 1; step();
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      amba_wr_flg = prev_rd_pop; step();
    end
    chk("throttle_issued5", 128'(dut_rd_issues - n0), 128'(5));
    rsp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      amba_wr_flg = prev_rd_pop; step();
    end

    // randomized traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cmd_valid   = ($urandom % 2) == 0;
      cmd_data    = IW'({$urandom, $urandom, $urandom});
      run         = ($urandom % 4) != 0;
      instr_rd    = ($urandom % 3) != 0;
      rsp_ready   = ($urandom % 3) == 0;
      amba_wr_flg = prev_rd_pop || (($urandom % 16) == 0);
      amba_slv_addr = $urandom; amba_slv_data = $urandom;
      rst         = ($urandom % 150) == 0;
      step();
    end
    zero_in(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_driver.md
Name: ahb_driver

Overview:
- Upstream neighbour of the AHB master.
- Buffers host-supplied AHB instruction words in a command FIFO and presents them to the master as amba_instr/amba_en, advancing on the master's instr_rd.
- Captures read-return data (amba_wr_flg/amba_slv_addr/amba_slv_data) into a response FIFO for the host.
- Throttles reads so that a returned read can never overflow the response FIFO.

Parameters:
- DWIDTH, 32, data width (matches ahb_fir_pkg).
- AWIDTH, 32, address width (matches ahb_fir_pkg).
- CMD_DEPTH, 8, command FIFO entries (power of 2, ≥2).
- RSP_DEPTH, 4, response FIFO entries (power of 2, ≥2).
- IW, DWIDTH+AWIDTH+6, instruction word width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- cmd_data  in  IW  instruction word {hwrite[1], hsize[3], htrans[2], haddr[AWIDTH], hwdata[DWIDTH]}, MSB first.
- cmd_valid  in  1  host push request.
- cmd_ready  out  1  command FIFO not full.
- run  in  1  issue enable; 0 freezes issue, push still allowed.
- amba_instr  out  IW  head command word to master.
- amba_en  out  1  head word valid and issuable.
- instr_rd  in  1  master accepts word this cycle (hready).
- amba_wr_flg  in  1  read data valid from master.
- amba_slv_addr  in  AWIDTH  address of returned read.
- amba_slv_data  in  DWIDTH  returned read data.
- rsp_data  out  AWIDTH+DWIDTH  {addr, data} at response FIFO head.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  host pop.
- cmd_count  out  $clog2(CMD_DEPTH)+1  command FIFO occupancy.
- rd_pending  out  2  issued reads not yet returned.
- idle  out  1  cmd empty, rd_pending==0, rsp empty.

Behaviour:
- Reset (rst high at posedge): both FIFOs empty; pointers and counts 0; rd_pending=0.
  - Outputs after reset: cmd_ready=1, amba_en=0, rsp_valid=0, idle=1.
  - amba_instr is the FIFO head output: don't-care while amba_en=0, but must not be X after reset.
- Reset mid-operation discards all queued commands and responses. No partial word is ever issued after reset.
- Command FIFO is show-ahead; amba_instr is always the head entry, driven combinationally from storage.
- Push: cmd_valid && cmd_ready writes at tail. Push into empty FIFO → visible on amba_instr the next cycle (1-cycle latency).
- Issue gate: amba_en = run && !cmd_empty && rd_ok.
  - rd_ok = 1 if head hwrite bit = 1.
  - For a read head: rd_ok = (rsp_count + rd_pending) < RSP_DEPTH.
- Pop: amba_en && instr_rd removes the head. The next entry appears on amba_instr in the same cycle after the edge (back-to-back issue, one word per hready cycle).
- instr_rd low: head held stable and amba_en held.
- Full command FIFO: push and pop in the same cycle are both performed; count unchanged. cmd_ready=0 only when the FIFO is full.
- rd_pending:
  - +1 on pop of a word with hwrite=0 (any htrans; the master flags every issued read).
  - −1 on amba_wr_flg.
  - Both in one cycle → unchanged.
  - Saturates at 3 and never underflows: amba_wr_flg with rd_pending=0 is still stored, with no decrement.
- Response FIFO:
  - amba_wr_flg writes {amba_slv_addr, amba_slv_data}.
  - rsp_ready && rsp_valid pops.
  - Simultaneous write and pop when full is allowed.
  - Write while full without a pop is dropped. This cannot occur when reads are gated as above.
- Arithmetic: occupancy counts are CMD/RSP_DEPTH+1 wide; pointers wrap modulo depth.

Optional Feature:
- Macro: AHB_DRIVER_STATS_EN.
- Defined: adds outputs wr_issued[15:0], rd_issued[15:0], stall_cycles[15:0].
  - wr_issued counts pops with hwrite=1.
  - rd_issued counts pops with hwrite=0.
  - stall_cycles counts cycles with run && !cmd_empty && (!rd_ok || !instr_rd).
  - All three wrap at 16 bits and clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with 3 queued words, then rst=1 for 1 cycle → cmd_count=0, amba_en=0, idle=1, rsp_valid=0.
- Push 4 writes (hsize=2, haddr=0x10..0x1C), run=1, instr_rd=1 → amba_en high 4 consecutive cycles, words in push order, then amba_en=0.
- Push 9 words with CMD_DEPTH=8, run=0 → cmd_ready=0 after the 8th push, 9th not accepted, cmd_count=8.
- instr_rd held low 3 cycles mid-stream → amba_instr and amba_en stable, no pop, cmd_count unchanged.
- RSP_DEPTH=4, rsp_ready=0, 6 reads queued, amba_wr_flg returned one cycle after each issue → exactly 4 reads issued, then amba_en=0. Pop one response → one more read issued.
- Simultaneous amba_wr_flg with read pop (rd_pending=1) → rd_pending stays 1. Response {0x20, 0xDEADBEEF} is stored and appears on rsp_data.
